// File: rtl/idli_pkg.sv
// Shared types for the idli core memory path.
package idli_pkg;

    typedef enum logic {
        SQI_MODE_IN  = 1'b0,
        SQI_MODE_OUT = 1'b1
    } sqi_mode_t;

endpackage

// File: rtl/idli_sqi_ctrl.sv
// Quad-SPI SRAM controller: one word read/write per request (cmd, addr, dummy, data).
// Define IDLI_SQI_INIT_EN to send EQIO on pin 0 after reset before accepting requests.
module idli_sqi_ctrl
    import idli_pkg::*;
#(
    parameter int ADDR_NIBBLES = 6,
    parameter int DATA_NIBBLES = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_req,
    input  logic                      i_wr,
    input  logic [ADDR_NIBBLES*4-1:0] i_addr,
    input  logic [DATA_NIBBLES*4-1:0] i_wdata,
    output logic                      o_ready,
    output logic [DATA_NIBBLES*4-1:0] o_rdata,
    output logic                      o_rvalid,
    output logic                      o_sqi_cs,
    output logic                      o_sqi_clk_en,
    output sqi_mode_t                 o_sqi_mode,
    output logic [3:0]                o_sqi_out,
    input  logic [3:0]                i_sqi_in
);

    localparam int AW      = ADDR_NIBBLES * 4;
    localparam int DW      = DATA_NIBBLES * 4;
    localparam int AIW     = $clog2(AW);
    localparam int DIW     = $clog2(DW);
    localparam int MAX_AD  = (ADDR_NIBBLES > DATA_NIBBLES) ? ADDR_NIBBLES : DATA_NIBBLES;
    localparam int CNT_MAX = (MAX_AD > 8) ? MAX_AD : 8;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] INIT_LAST  = CW'(8);
    localparam logic [CW-1:0] CMD_LAST   = CW'(1);
    localparam logic [CW-1:0] ADDR_LAST  = CW'(ADDR_NIBBLES - 1);
    localparam logic [CW-1:0] DUMMY_LAST = CW'(1);
    localparam logic [CW-1:0] DATA_LAST  = CW'(DATA_NIBBLES - 1);

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] EQIO      = 8'h38;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_DONE
    } state_t;

`ifdef IDLI_SQI_INIT_EN
    localparam state_t RESET_STATE = ST_INIT;
    localparam logic   RESET_READY = 1'b0;
`else
    localparam state_t RESET_STATE = ST_IDLE;
    localparam logic   RESET_READY = 1'b1;
`endif

    state_t          state_q,  state_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic            wr_q,     wr_d;
    logic [AW-1:0]   addr_q,   addr_d;
    logic [DW-1:0]   wdata_q,  wdata_d;
    logic [DW-1:0]   shift_q,  shift_d;
    logic [DW-1:0]   rdata_q,  rdata_d;
    logic            rvalid_q, rvalid_d;
    logic            ready_q,  ready_d;
    logic            cs_q,     cs_d;
    logic            clkEn_q,  clkEn_d;
    sqi_mode_t       mode_q,   mode_d;
    logic [3:0]      sqiOut_q, sqiOut_d;

    logic [CW-1:0]   addrNib;
    logic [CW-1:0]   dataNib;
    logic [AIW-1:0]  addrBase;
    logic [DIW-1:0]  dataBase;
    logic [2:0]      initBit;
    logic [7:0]      cmdByte;

    // INIT counts 1..8 after reset so that cycle 0 already shows the first EQIO bit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        shift_d  = shift_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (cnt_q == INIT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_IDLE: begin
                if (i_req) begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                    wr_d    = i_wr;
                    addr_d  = i_addr;
                    wdata_d = i_wdata;
                end
            end
            ST_CMD: begin
                if (cnt_q == CMD_LAST) begin
                    state_d = ST_ADDR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_ADDR: begin
                if (cnt_q == ADDR_LAST) begin
                    state_d = wr_q ? ST_DATA : ST_DUMMY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DUMMY: begin
                if (cnt_q == DUMMY_LAST) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (!wr_q) begin
                    shift_d = (shift_q << 4) | DW'(i_sqi_in);
                end
                if (cnt_q == DATA_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    if (!wr_q) begin
                        rdata_d  = shift_d;
                        rvalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin outputs are decoded from the next state so they can be registered.
    always_comb begin
        cs_d     = 1'b1;
        clkEn_d  = 1'b0;
        mode_d   = SQI_MODE_IN;
        sqiOut_d = 4'h0;
        ready_d  = 1'b0;

        addrNib  = ADDR_LAST - cnt_d;
        dataNib  = DATA_LAST - cnt_d;
        addrBase = AIW'({addrNib, 2'b00});
        dataBase = DIW'({dataNib, 2'b00});
        initBit  = 3'(INIT_LAST - cnt_d);
        cmdByte  = wr_d ? CMD_WRITE : CMD_READ;

        case (state_d)
            ST_INIT: begin
                cs_d     = 1'b0;
                clkEn_d  = 1'b1;
                mode_d   = SQI_MODE_OUT;
                sqiOut_d = {3'b000, EQIO[initBit]};
            end
            ST_IDLE: begin
                ready_d = 1'b1;
            end
            ST_CMD: begin
                cs_d     = 1'b0;
                clkEn_d  = 1'b1;
                mode_d   = SQI_MODE_OUT;
                sqiOut_d = (cnt_d == '0) ? cmdByte[7:4] : cmdByte[3:0];
            end
            ST_ADDR: begin
                cs_d     = 1'b0;
                clkEn_d  = 1'b1;
                mode_d   = SQI_MODE_OUT;
                sqiOut_d = addr_d[addrBase +: 4];
            end
            ST_DUMMY: begin
                cs_d    = 1'b0;
                clkEn_d = 1'b1;
            end
            ST_DATA: begin
                cs_d    = 1'b0;
                clkEn_d = 1'b1;
                if (wr_d) begin
                    mode_d   = SQI_MODE_OUT;
                    sqiOut_d = wdata_d[dataBase +: 4];
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= RESET_STATE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            shift_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ready_q  <= RESET_READY;
            cs_q     <= 1'b1;
            clkEn_q  <= 1'b0;
            mode_q   <= SQI_MODE_IN;
            sqiOut_q <= 4'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            shift_q  <= shift_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ready_q  <= ready_d;
            cs_q     <= cs_d;
            clkEn_q  <= clkEn_d;
            mode_q   <= mode_d;
            sqiOut_q <= sqiOut_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_rdata      = rdata_q;
    assign o_rvalid     = rvalid_q;
    assign o_sqi_cs     = cs_q;
    assign o_sqi_clk_en = clkEn_q;
    assign o_sqi_mode   = mode_q;
    assign o_sqi_out    = sqiOut_q;

endmodule
